// File: rtl/demux1_to_4_reg.sv
// rtl/demux1_to_4_reg.sv - Registered 1-to-4 demultiplexer with per-channel valid/ready holding slots
//
// Purpose:
//   Routes one WIDTH-bit input word (valid/ready handshake) to one of four
//   single-entry output slots chosen by in_sel. Each slot presents its word
//   with its own valid/ready handshake. A slot that drains and loads in the
//   same cycle keeps valid high, so one word per cycle can stream through.
//
// Optional feature:
//   DEMUX_CNT_EN - when defined, adds per-channel CNT_W-bit transfer counters
//                  (count out_valid[k] && out_ready[k] handshakes, wrap silently)
//                  and the out_cnt port. When undefined, neither exists.
//
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          synchronous active-high reset
//   in_valid   in   1          input word present
//   in_ready   out  1          input word accepted when in_valid && in_ready
//   in_sel     in   2          destination channel 0..3
//   in_data    in   WIDTH      input word
//   out_valid  out  4          bit k: slot k holds a word
//   out_ready  in   4          bit k: consumer k takes the word this cycle
//   out_data0..out_data3 out WIDTH  slot contents (retained while idle)
//   out_cnt    out  4*CNT_W    (DEMUX_CNT_EN only) channel k count at [k*CNT_W +: CNT_W]

module demux1_to_4_reg #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3
`ifdef DEMUX_CNT_EN
    ,
    output logic [4*CNT_W-1:0] out_cnt
`endif
);

    logic [3:0]       valid_q, valid_d;
    logic [WIDTH-1:0] slot_q [4];
    logic [WIDTH-1:0] slot_d [4];
    logic [3:0]       drain;
    logic             load;

    // in_ready looks only at the selected slot: a full slot whose consumer
    // is taking its word this cycle can accept a replacement immediately.
    always_comb begin
        in_ready = !valid_q[in_sel] || out_ready[in_sel];
        load     = in_valid && in_ready;
        drain    = valid_q & out_ready;
    end

    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < 4; k++) begin
            slot_d[k] = slot_q[k];
            if (drain[k]) begin
                valid_d[k] = 1'b0;
            end
            // A load overrides a same-cycle drain so the slot stays valid.
            if (load && (in_sel == 2'(k))) begin
                valid_d[k] = 1'b1;
                slot_d[k]  = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < 4; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    always_comb begin
        out_valid = valid_q;
        out_data0 = slot_q[0];
        out_data1 = slot_q[1];
        out_data2 = slot_q[2];
        out_data3 = slot_q[3];
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Counters wrap naturally at 2^CNT_W.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(drain[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        out_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            out_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end
`endif

endmodule
